alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit datapath.
- Sequences instruction fetch, decode, ALU execute, data-memory access and register write-back.
- Drives the ALU function select (alufn) and consumes the ALU equality flag (alubeq) for branches.
- Handles variable memory latency through a ready handshake, with a watchdog timeout.

Parameters:
- TIMEOUT, 16, max consecutive wait cycles (mem_ready=0) in FETCH or MEM before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  3  opcode field from instruction register; valid from DECODE onward.
- alubeq  in  1  ALU compare flag: 0 = operands equal, 1 = not equal.
- mem_ready  in  1  memory completes the current read/write this cycle.
- alufn  out  3  ALU function select.
- alu_src  out  1  ALU B input: 0 = Rb, 1 = immediate.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- pc_sel  out  1  PC source: 0 = PC+1, 1 = branch target.
- rf_we  out  1  register file write.
- wb_sel  out  1  write-back data: 0 = ALU result, 1 = memory data.
- mem_err  out  1  one-cycle pulse on watchdog abort.
- instr_count  out  8  retired-instruction counter.
- state  out  3  debug state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Behaviour:
- Reset (async): state=FETCH, op_q=0, wait counter=0, instr_count=0, mem_err=0. While reset is high, every request and enable output is forced 0.
- Control outputs are Moore (decoded from state and op_q) except handshake-qualified enables. Any output not listed for a state is 0.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADDI, 101 LW, 110 SW, 111 BEQ.
- FETCH: mem_re=1, addr_sel=0.
  - mem_ready=1: ir_we=1, pc_we=1, pc_sel=0 in the same cycle; go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: latch op_q<=opcode; go to EXEC.
- EXEC: alufn=op_q; alu_src=1 for 100/101/110, else 0.
  - 000-100: go to WB.
  - 101/110: go to MEM.
  - 111: sample alubeq this cycle. If alubeq=0 (taken), pc_we=1 and pc_sel=1. Go to FETCH and retire.
- MEM: addr_sel=1; alufn held at op_q; mem_re=1 for LW, mem_we=1 for SW. Hold these until mem_ready=1.
  - LW: go to WB.
  - SW: go to FETCH and retire.
- WB: rf_we=1; wb_sel=1 for LW, else 0; go to FETCH and retire.
- Latency with zero-wait memory (cycles from FETCH entry to next FETCH): ALU ops 4, LW 5, SW 4, BEQ 3.
- Retire: instr_count+1, wraps 255->0.
- Wait counter:
  - Clears on every state change.
  - Counts cycles in FETCH/MEM with mem_ready=0.
  - On the cycle the count reaches TIMEOUT: mem_err=1 for one cycle, go to FETCH, no retire, no pc_we/ir_we/rf_we.
  - An aborted SW write has no architectural effect beyond memory.
- mem_ready=1 on the same cycle the count reaches TIMEOUT: the handshake wins, with no error.
- mem_ready ignored outside FETCH/MEM.
- Reset mid-instruction: immediate return to FETCH; no write enable may glitch high.

Test Plan:
- Reset: hold reset 3 cycles, release -> state=0, instr_count=0. All enables 0 during reset; mem_re=1 in the first post-reset cycle.
- ADD, mem_ready tied 1 -> state sequence 0,1,2,4,0. alufn=000 in EXEC; rf_we=1 for exactly 1 cycle with wb_sel=0; instr_count 0->1.
- LW, mem_ready low 3 cycles in MEM -> mem_re and addr_sel=1 held 4 cycles. WB has rf_we=1, wb_sel=1. Total 8 cycles.
- BEQ, alubeq=0 -> in EXEC pc_we=1, pc_sel=1, alufn=111; back to FETCH. BEQ, alubeq=1 -> pc_we stays 0; instr_count still increments.
- Timeout (TIMEOUT=16): mem_ready=0 forever in FETCH -> mem_err pulses at the 16th wait cycle; state returns to 0; ir_we never 1; instr_count unchanged.
- Wrap and async reset: 256 retired SW instructions -> instr_count returns to 0. Reset asserted mid-MEM -> mem_we drops in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_seq_if.sv
// Control bus between the multi-cycle sequencer and the 8-bit datapath/memory.
interface alu_seq_if;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  // Datapath/memory -> sequencer
  logic [OP_W-1:0]  opcode;
  logic             alubeq;
  logic             mem_ready;

  // Sequencer -> datapath/memory
  logic [OP_W-1:0]  alufn;
  logic             alu_src;
  logic             mem_re;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             rf_we;
  logic             wb_sel;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;
  logic [ST_W-1:0]  state;

  // Datapath side: supplies opcode/flags/handshake, observes controls
  modport master (
    output opcode, alubeq, mem_ready,
    input  alufn, alu_src, mem_re, mem_we, addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, mem_err, instr_count, state
  );

  // Sequencer side
  modport slave (
    input  opcode, alubeq, mem_ready,
    output alufn, alu_src, mem_re, mem_we, addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, mem_err, instr_count, state
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory access, write-back,
// with a ready handshake on memory and a watchdog on consecutive wait cycles.
module alu_seq_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_ADDI = 3'd4;
  localparam logic [OP_W-1:0] OP_LW   = 3'd5;
  localparam logic [OP_W-1:0] OP_SW   = 3'd6;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [OP_W-1:0]   alufn_c;
  logic              alu_src_c;
  logic              mem_re_c;
  logic              mem_we_c;
  logic              addr_sel_c;
  logic              ir_we_c;
  logic              pc_we_c;
  logic              pc_sel_c;
  logic              rf_we_c;
  logic              wb_sel_c;
  logic              at_limit_c;
  logic              imm_op_c;

  // This wait cycle would be the TIMEOUT-th consecutive one
  assign at_limit_c = (wait_q == WAIT_W'(TIMEOUT - 1));

  // ADDI/LW/SW take the immediate as ALU operand B
  assign imm_op_c = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);

  // State, latched opcode, wait counter, retire counter and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and Moore/handshake-qualified control decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = '0;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    alufn_c    = '0;
    alu_src_c  = 1'b0;
    mem_re_c   = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    rf_we_c    = 1'b0;
    wb_sel_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_re_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (at_limit_c) begin
          // Abort: restart fetch with a fresh wait count
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        alufn_c   = op_q;
        alu_src_c = imm_op_c;
        if (op_q == OP_BEQ) begin
          // alubeq low means operands equal: branch taken
          pc_we_c  = ~bus.alubeq;
          pc_sel_c = ~bus.alubeq;
          state_d  = S_FETCH;
          cnt_d    = cnt_q + CNT_W'(1);
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        addr_sel_c = 1'b1;
        alufn_c    = op_q;
        mem_re_c   = (op_q == OP_LW);
        mem_we_c   = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (at_limit_c) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        rf_we_c  = 1'b1;
        wb_sel_c = (op_q == OP_LW);
        state_d  = S_FETCH;
        cnt_d    = cnt_q + CNT_W'(1);
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset overrides the decode combinationally so nothing glitches high
    if (reset) begin
      alufn_c    = '0;
      alu_src_c  = 1'b0;
      mem_re_c   = 1'b0;
      mem_we_c   = 1'b0;
      addr_sel_c = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      pc_sel_c   = 1'b0;
      rf_we_c    = 1'b0;
      wb_sel_c   = 1'b0;
    end
  end

  assign bus.alufn       = alufn_c;
  assign bus.alu_src     = alu_src_c;
  assign bus.mem_re      = mem_re_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.addr_sel    = addr_sel_c;
  assign bus.ir_we       = ir_we_c;
  assign bus.pc_we       = pc_we_c;
  assign bus.pc_sel      = pc_sel_c;
  assign bus.rf_we       = rf_we_c;
  assign bus.wb_sel      = wb_sel_c;
  assign bus.mem_err     = err_q;
  assign bus.instr_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: builds the expected per-cycle trace of each
// instruction from its opcode and memory wait pattern, then replays it.
module tb_alu_seq_ctrl;

  localparam int unsigned TIMEOUT = 16;

  // Control bit masks within the 9-bit control field of an expected vector
  localparam logic [8:0] C_SRC  = 9'h100;
  localparam logic [8:0] C_RE   = 9'h080;
  localparam logic [8:0] C_WE   = 9'h040;
  localparam logic [8:0] C_ASEL = 9'h020;
  localparam logic [8:0] C_IRWE = 9'h010;
  localparam logic [8:0] C_PCWE = 9'h008;
  localparam logic [8:0] C_PSEL = 9'h004;
  localparam logic [8:0] C_RFWE = 9'h002;
  localparam logic [8:0] C_WBS  = 9'h001;

  typedef struct {
    logic        rdy;
    logic [2:0]  opc;
    logic        beq;
    logic [23:0] exp;  // {state, alufn, ctl[8:0], mem_err, instr_count}
  } cyc_t;

  logic clk;
  logic reset;
  alu_seq_if bus();

  alu_seq_ctrl #(.TIMEOUT(TIMEOUT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cyc_t       q[$];
  logic [7:0] m_cnt;
  logic       m_err;
  int         n_tests;
  int         n_fail;
  int         cyc_idx;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] r3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [23:0] act_vec();
    return {bus.state, bus.alufn, bus.alu_src, bus.mem_re, bus.mem_we,
            bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_sel, bus.rf_we,
            bus.wb_sel, bus.mem_err, bus.instr_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One expected cycle: inputs to apply and outputs that must result
  task automatic emit(input logic [2:0] st, input logic rdy, input logic [2:0] opc,
                      input logic beq, input logic [2:0] fn, input logic [8:0] ctl);
    cyc_t c;
    c.rdy = rdy;
    c.opc = opc;
    c.beq = beq;
    c.exp = {st, fn, ctl, m_err, m_cnt};
    m_err = 1'b0;
    q.push_back(c);
  endtask

  // Expected trace of one instruction: fw wait cycles before fetch completes,
  // mw wait cycles before the memory access completes; TIMEOUT waits abort.
  task automatic gen_instr(input logic [2:0] op, input int fw, input int mw, input logic beq);
    logic       is_lw;
    logic       is_sw;
    logic [8:0] src;
    logic [8:0] mctl;
    is_lw = (op == 3'd5);
    is_sw = (op == 3'd6);
    src   = (op >= 3'd4 && op <= 3'd6) ? C_SRC : 9'h000;
    mctl  = C_ASEL | (is_lw ? C_RE : C_WE);
    for (int i = 0; i < fw; i++) begin
      emit(3'd0, 1'b0, r3(), rb(), 3'd0, C_RE);
      if (i == int'(TIMEOUT) - 1) begin
        m_err = 1'b1;
        return;
      end
    end
    emit(3'd0, 1'b1, r3(), rb(), 3'd0, C_RE | C_IRWE | C_PCWE);
    emit(3'd1, rb(), op, rb(), 3'd0, 9'h000);
    if (op == 3'd7) begin
      emit(3'd2, rb(), op, beq, op, src | (beq ? 9'h000 : (C_PCWE | C_PSEL)));
      m_cnt = m_cnt + 8'd1;
      return;
    end
    emit(3'd2, rb(), op, rb(), op, src);
    if (is_lw || is_sw) begin
      for (int i = 0; i < mw; i++) begin
        emit(3'd3, 1'b0, op, rb(), op, mctl);
        if (i == int'(TIMEOUT) - 1) begin
          m_err = 1'b1;
          return;
        end
      end
      emit(3'd3, 1'b1, op, rb(), op, mctl);
      if (is_sw) begin
        m_cnt = m_cnt + 8'd1;
        return;
      end
    end
    emit(3'd4, rb(), op, rb(), 3'd0, C_RFWE | (is_lw ? C_WBS : 9'h000));
    m_cnt = m_cnt + 8'd1;
  endtask

  // Replay up to n queued cycles (all if n < 0); entered and left at a negedge
  task automatic run_q(input int n);
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      cyc_t c;
      c = q.pop_front();
      bus.mem_ready = c.rdy;
      bus.opcode    = c.opc;
      bus.alubeq    = c.beq;
      #1;
      check($sformatf("cyc%0d", cyc_idx), 32'(act_vec()), 32'(c.exp));
      cyc_idx++;
      k++;
      @(negedge clk);
    end
  endtask

  function automatic int pick_waits();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return int'(TIMEOUT);
    if (r == 1) return int'(TIMEOUT) - 1;
    if (r < 5)  return int'($urandom_range(1, 4));
    return 0;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc_idx = 0;
    m_cnt   = 8'd0;
    m_err   = 1'b0;
    reset   = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 3'd0;
    bus.alubeq    = 1'b0;

    // Everything low while reset is held
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_outputs", 32'(act_vec()), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // ADD with zero-wait memory: states 0,1,2,4
    gen_instr(3'd0, 0, 0, 1'b0);
    check("add_len", 32'(q.size()), 32'd4);
    check("add_states", 32'({q[0].exp[23:21], q[1].exp[23:21], q[2].exp[23:21], q[3].exp[23:21]}),
          32'({3'd0, 3'd1, 3'd2, 3'd4}));
    run_q(-1);
    check("add_count", 32'(bus.instr_count), 32'd1);

    // LW with three wait cycles in MEM takes 8 cycles
    gen_instr(3'd5, 0, 3, 1'b0);
    check("lw_len", 32'(q.size()), 32'd8);
    run_q(-1);
    gen_instr(3'd6, 0, 0, 1'b0);
    check("sw_len", 32'(q.size()), 32'd4);
    run_q(-1);
    gen_instr(3'd7, 0, 0, 1'b0);
    check("beq_taken_len", 32'(q.size()), 32'd3);
    run_q(-1);
    gen_instr(3'd7, 0, 0, 1'b1);
    run_q(-1);
    check("count_after_5", 32'(bus.instr_count), 32'd5);

    // Fetch watchdog: 16 wait cycles then error pulse, nothing retired
    gen_instr(r3(), int'(TIMEOUT), 0, 1'b0);
    check("fetch_to_len", 32'(q.size()), 32'd16);
    run_q(-1);
    check("fetch_to_err", 32'(bus.mem_err), 32'd1);
    check("fetch_to_state", 32'(bus.state), 32'd0);
    check("fetch_to_count", 32'(bus.instr_count), 32'd5);

    // Memory watchdog on a load
    gen_instr(3'd5, 0, int'(TIMEOUT), 1'b0);
    check("mem_to_len", 32'(q.size()), 32'd19);
    run_q(-1);
    check("mem_to_err", 32'(bus.mem_err), 32'd1);
    check("mem_to_count", 32'(bus.instr_count), 32'd5);

    // Ready on the last allowed wait cycle completes without error
    gen_instr(3'd6, int'(TIMEOUT) - 1, int'(TIMEOUT) - 1, 1'b0);
    check("edge_len", 32'(q.size()), 32'd34);
    run_q(-1);
    check("edge_count", 32'(bus.instr_count), 32'd6);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      gen_instr(r3(), pick_waits(), pick_waits(), rb());
      run_q(-1);
    end

    // Asynchronous reset while a store waits in MEM
    gen_instr(3'd6, 0, 5, 1'b0);
    run_q(4);
    q.delete();
    #2;
    check("pre_rst_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_we", 32'(bus.mem_we), 32'd0);
    check("async_rst_all", 32'(act_vec()), 32'd0);
    @(negedge clk);
    #1;
    check("rst_hold_all", 32'(act_vec()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 8'd0;
    m_err = 1'b0;

    // 256 retired stores wrap the counter back to 0
    for (int n = 0; n < 256; n++) begin
      gen_instr(3'd6, 0, 0, 1'b0);
      run_q(-1);
      if (n == 254) check("count_255", 32'(bus.instr_count), 32'd255);
    end
    check("count_wrap", 32'(bus.instr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
